// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer
//   On-chip capture of processor debug outputs. After an arm pulse the block
//   waits for an instruction that matches a masked trigger pattern. From that
//   cycle onward it records one entry per cycle into a circular buffer:
//   {stamp, Instr, Result, ALUFlags, ctrl}. A host drains the buffer through a
//   first-word-fall-through valid/ready port.
// Ports
//   CLK, RST                   clock (rising edge), async active-high reset
//   arm, stop                  1-cycle control pulses (arm > stop > trigger hit)
//   trig_val, trig_mask        trigger pattern/mask compared against Instr
//   Instr, Result, ALUFlags    processor observation inputs
//   RegWrite, MemWrite, PCSrc  control bits, stored as {PCSrc,MemWrite,RegWrite}
//   rd_ready                   reader accepts the head entry
//   rd_valid, rd_*             head entry (all zero while empty)
//   count                      occupancy 0..DEPTH
//   overflow                   sticky: a capture was dropped on a full buffer
//   state                      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
module instr_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int STAMP_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               arm,
    input  logic               stop,
    input  logic [31:0]        trig_val,
    input  logic [31:0]        trig_mask,
    input  logic [31:0]        Instr,
    input  logic [31:0]        Result,
    input  logic [3:0]         ALUFlags,
    input  logic               RegWrite,
    input  logic               MemWrite,
    input  logic               PCSrc,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [STAMP_W-1:0] rd_stamp,
    output logic [31:0]        rd_instr,
    output logic [31:0]        rd_result,
    output logic [3:0]         rd_flags,
    output logic [2:0]         rd_ctrl,
    output logic [AW:0]        count,
    output logic               overflow,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [31:0]        instr;
        logic [31:0]        result;
        logic [3:0]         flags;
        logic [2:0]         ctrl;
    } entry_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [STAMP_W-1:0] stamp_q;
    entry_t             mem_q [DEPTH];

    logic   hit, cap, full, push, pop;
    entry_t wr_entry, head;

    assign hit  = ((Instr ^ trig_val) & trig_mask) == 32'd0;
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) && rd_ready;

    assign wr_entry = '{stamp:  stamp_q,
                        instr:  Instr,
                        result: Result,
                        flags:  ALUFlags,
                        ctrl:   {PCSrc, MemWrite, RegWrite}};

    // Next-state; cap marks a cycle whose inputs belong in the trace.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (arm)       state_d = S_ARMED;
                else if (stop) state_d = S_DONE;
                else if (hit) begin
                    state_d = S_CAPTURE;
                    cap     = 1'b1;       // trigger cycle is itself recorded
                end
            end
            S_CAPTURE: begin
                if (arm)       state_d = S_ARMED;
                else if (stop) state_d = S_DONE;
                else           cap     = 1'b1;
            end
            S_DONE: begin
                if (arm) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full buffer still accepts a write when the head is popped the same cycle.
    assign push = cap && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (arm) begin
            // Flush wins over any read or write in the arm cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
            if (cap && !push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            stamp_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            stamp_q  <= stamp_q + 1'b1;
        end
    end

    // Storage has no reset; the read port is masked while empty instead.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head      = mem_q[rd_ptr_q];
    assign rd_valid  = (count_q != '0);
    assign rd_stamp  = rd_valid ? head.stamp  : '0;
    assign rd_instr  = rd_valid ? head.instr  : '0;
    assign rd_result = rd_valid ? head.result : '0;
    assign rd_flags  = rd_valid ? head.flags  : '0;
    assign rd_ctrl   = rd_valid ? head.ctrl   : '0;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
module tb_instr_trace_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        arm, stop, RegWrite, MemWrite, PCSrc, rd_ready;
    logic [31:0] trig_val, trig_mask, Instr, Result;
    logic [3:0]  ALUFlags;
    logic        rd_valid, overflow;
    logic [15:0] rd_stamp;
    logic [31:0] rd_instr, rd_result;
    logic [3:0]  rd_flags;
    logic [2:0]  rd_ctrl;
    logic [4:0]  count;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference cycle counter: value during a cycle is the stamp a capture records.
    logic [15:0] cyc;
    logic [15:0] sA, sB, sC;

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST)
        if (RST) cyc <= '0;
        else     cyc <= cyc + 1'b1;

    instr_trace_buffer #(.DEPTH(16), .AW(4), .STAMP_W(16)) dut (
        .CLK(CLK), .RST(RST), .arm(arm), .stop(stop),
        .trig_val(trig_val), .trig_mask(trig_mask),
        .Instr(Instr), .Result(Result), .ALUFlags(ALUFlags),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_stamp(rd_stamp),
        .rd_instr(rd_instr), .rd_result(rd_result), .rd_flags(rd_flags),
        .rd_ctrl(rd_ctrl), .count(count), .overflow(overflow), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain_chk(input string tag, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            chk(tag, rd_instr, base + 32'(i));
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        chk({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; arm = 0; stop = 0; RegWrite = 0; MemWrite = 0; PCSrc = 0;
        rd_ready = 0; trig_val = 0; trig_mask = 0; Instr = 0; Result = 0; ALUFlags = 0;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_instr", rd_instr, 32'd0);
        #11 RST = 1'b0;
        tick();

        // Immediate trigger, three captured instructions.
        trig_mask = 32'h0;
        arm = 1; tick(); arm = 0;
        chk("t2_armed", 32'(state), 32'd1);
        Instr = 32'hA; sA = cyc; tick();
        chk("t2_cap", 32'(state), 32'd2);
        Instr = 32'hB; sB = cyc; tick();
        Instr = 32'hC; sC = cyc; tick();
        stop = 1; Instr = 32'hD; tick(); stop = 0;
        chk("t2_done", 32'(state), 32'd3);
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_iA", rd_instr, 32'hA);
        chk("t2_sA", 32'(rd_stamp), 32'(sA));
        tick();
        chk("t2_hold", rd_instr, 32'hA);
        rd_ready = 1; tick();
        chk("t2_iB", rd_instr, 32'hB);
        chk("t2_sB", 32'(rd_stamp), 32'(sB));
        chk("t2_seq", 32'(sB), 32'(sA + 16'd1));
        tick();
        chk("t2_iC", rd_instr, 32'hC);
        chk("t2_sC", 32'(rd_stamp), 32'(sC));
        tick(); rd_ready = 0;
        chk("t2_cnt0", 32'(count), 32'd0);
        chk("t2_val0", 32'(rd_valid), 32'd0);

        // Exact-match trigger on the fourth instruction.
        trig_mask = 32'hFFFF_FFFF; trig_val = 32'hE281_1001;
        arm = 1; tick(); arm = 0;
        Instr = 32'hE281_1002; tick(); chk("t3_w1", 32'(state), 32'd1);
        Instr = 32'h0000_0000; tick(); chk("t3_w2", 32'(state), 32'd1);
        Instr = 32'h6281_1001; tick(); chk("t3_w3", 32'(state), 32'd1);
        Instr = 32'hE281_1001; Result = 32'h1234; ALUFlags = 4'b1010;
        RegWrite = 1; PCSrc = 1;
        tick();
        RegWrite = 0; PCSrc = 0; Result = 0; ALUFlags = 0;
        chk("t3_cap", 32'(state), 32'd2);
        stop = 1; Instr = 32'h1; tick(); stop = 0;
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_instr", rd_instr, 32'hE281_1001);
        chk("t3_result", rd_result, 32'h1234);
        chk("t3_flags", 32'(rd_flags), 32'hA);
        chk("t3_ctrl", 32'(rd_ctrl), 32'h5);

        // Overflow: 20 captures into 16 entries with no reader.
        trig_mask = 32'h0;
        arm = 1; tick(); arm = 0;
        chk("t4_flush", 32'(count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            Instr = 32'h100 + 32'(i); tick();
        end
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_state", 32'(state), 32'd2);
        stop = 1; tick(); stop = 0;
        drain_chk("t4_drain", 16, 32'h100);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        arm = 1; tick(); arm = 0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        // Full buffer with a concurrent reader: push+pop each cycle.
        for (int i = 0; i < 16; i++) begin
            Instr = 32'h200 + 32'(i); tick();
        end
        chk("t5_full", 32'(count), 32'd16);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        rd_ready = 1;
        for (int j = 0; j < 8; j++) begin
            Instr = 32'h210 + 32'(j); tick();
            chk("t5_cnt", 32'(count), 32'd16);
        end
        chk("t5_ovf", 32'(overflow), 32'd0);
        rd_ready = 0; stop = 1; tick(); stop = 0;
        chk("t5_stop_cnt", 32'(count), 32'd16);
        drain_chk("t5_drain", 16, 32'h208);

        // rd_ready while empty; stop vs hit; arm vs stop.
        rd_ready = 1; tick(); rd_ready = 0;
        chk("t6_empty_rd", 32'(count), 32'd0);
        arm = 1; tick(); arm = 0;
        chk("t6_armed", 32'(state), 32'd1);
        stop = 1; Instr = 32'h55; tick(); stop = 0;
        chk("t6_stop_hit", 32'(state), 32'd3);
        chk("t6_cnt", 32'(count), 32'd0);
        arm = 1; stop = 1; tick(); arm = 0; stop = 0;
        chk("t6_arm_stop", 32'(state), 32'd1);

        // Asynchronous reset in the middle of a capture.
        for (int i = 0; i < 5; i++) begin
            Instr = 32'h300 + 32'(i); tick();
        end
        chk("t1_pre_cnt", 32'(count), 32'd5);
        chk("t1_pre_state", 32'(state), 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("t1_state", 32'(state), 32'd0);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_valid", 32'(rd_valid), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        chk("t1_instr", rd_instr, 32'd0);
        #1 RST = 1'b0;
        tick();
        chk("t1_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
